// File: rtl/logic_op_pkg.sv
// Shared definitions for the logic-op sequencer: op codes, self-test FSM state
// type and the golden self-test signature.
package logic_op_pkg;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_NAND = 2'b10;
  localparam logic [1:0] OP_NOR  = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } st_state_e;

  // Signature from the 16 self-test vectors, taken on bit 0 of each result.
  localparam logic [15:0] ST_SIG_GOLDEN = 16'h366C;

endpackage

// File: rtl/logic_unit_core.sv
// Combinational W-bit two-input logic unit.
// Ports:
//   op  in  2  operation select (AND/OR/NAND/NOR)
//   a   in  W  operand a
//   b   in  W  operand b
//   y   out W  bitwise op(a, b)
module logic_unit_core
  import logic_op_pkg::*;
#(
  parameter int unsigned W = 1
) (
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  always_comb begin
    y = '0;
    unique case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/logic_op_sequencer.sv
// Command FIFO and issue stage in front of the logic unit. Commands {op, a, b}
// are queued, the FIFO head goes through the logic unit on each pop and the
// result is registered with its op code.
// Optional built-in self-test is enabled by defining LU_SELFTEST_EN.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   flush                 sync clear of FIFO and output register
//   in_valid/in_ready     command handshake; in_op, in_a, in_b command fields
//   out_valid/out_ready   result handshake; out_data, out_op result fields
//   level                 FIFO occupancy
//   done_cnt              results consumed (wrapping)
//   st_start/st_busy/st_done/st_sig  self-test control/status (LU_SELFTEST_EN only)
module logic_op_sequencer
  import logic_op_pkg::*;
#(
  parameter int unsigned W     = 1,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned LW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    in_op,
  input  logic [W-1:0]  in_a,
  input  logic [W-1:0]  in_b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic [1:0]    out_op,
  output logic [LW-1:0] level,
  output logic [15:0]   done_cnt
`ifdef LU_SELFTEST_EN
  ,
  input  logic          st_start,
  output logic          st_busy,
  output logic          st_done,
  output logic [15:0]   st_sig
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q;
  logic [1:0]    op_mem [DEPTH];
  logic [W-1:0]  a_mem  [DEPTH];
  logic [W-1:0]  b_mem  [DEPTH];
  logic          out_valid_q;
  logic [W-1:0]  out_data_q;
  logic [1:0]    out_op_q;
  logic [15:0]   done_cnt_q;

  logic          busy;
  logic          push_valid;
  logic [1:0]    push_op;
  logic [W-1:0]  push_a, push_b;
  logic          sink_ready;
  logic          full, empty, push, pop, consume;
  logic [W-1:0]  lu_y;

  assign full       = (level_q == LW'(DEPTH));
  assign empty      = (level_q == '0);
  // The self-test owns the output side while running and never stalls it.
  assign sink_ready = busy | out_ready;
  assign consume    = out_valid_q & sink_ready;
  assign pop        = ~empty & (~out_valid_q | sink_ready);
  // A full FIFO blocks the push even if a pop frees a slot this cycle.
  assign push       = push_valid & ~full;

  logic_unit_core #(
    .W (W)
  ) u_core (
    .op (op_mem[rd_ptr_q]),
    .a  (a_mem[rd_ptr_q]),
    .b  (b_mem[rd_ptr_q]),
    .y  (lu_y)
  );

  always_ff @(posedge clk) begin
    if (push) begin
      op_mem[wr_ptr_q] <= push_op;
      a_mem[wr_ptr_q]  <= push_a;
      b_mem[wr_ptr_q]  <= push_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_op_q    <= '0;
    end else if (flush) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_op_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
      if (pop) begin
        out_valid_q <= 1'b1;
        out_data_q  <= lu_y;
        out_op_q    <= op_mem[rd_ptr_q];
      end else if (consume) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_cnt_q <= '0;
    end else if (consume) begin
      done_cnt_q <= done_cnt_q + 16'd1;
    end
  end

`ifdef LU_SELFTEST_EN
  st_state_e   st_q, st_d;
  logic [3:0]  vec_q;
  logic [3:0]  res_q;
  logic [15:0] sig_q;
  logic        st_go;

  assign st_go = st_start & ~flush & ((st_q == StIdle) | (st_q == StDone));
  assign busy  = (st_q == StRun) | (st_q == StDrain);

  always_comb begin
    st_d = st_q;
    if (flush) begin
      st_d = StIdle;
    end else begin
      unique case (st_q)
        StIdle, StDone: if (st_start) st_d = StRun;
        StRun:          if (push && vec_q == 4'hF) st_d = StDrain;
        StDrain:        if (consume && res_q == 4'hF) st_d = StDone;
        default:        st_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q  <= StIdle;
      vec_q <= '0;
      res_q <= '0;
      sig_q <= '0;
    end else begin
      st_q <= st_d;
      if (st_go) begin
        vec_q <= '0;
        res_q <= '0;
        sig_q <= '0;
      end else begin
        if (st_q == StRun && push) vec_q <= vec_q + 4'd1;
        if (busy && consume) begin
          res_q <= res_q + 4'd1;
          sig_q <= {sig_q[14:0], out_data_q[0]};
        end
      end
    end
  end

  // Vector counter bits are {a_bit, b_bit, op}.
  always_comb begin
    if (busy) begin
      push_valid = (st_q == StRun);
      push_op    = vec_q[1:0];
      push_a     = {W{vec_q[3]}};
      push_b     = {W{vec_q[2]}};
    end else begin
      push_valid = in_valid;
      push_op    = in_op;
      push_a     = in_a;
      push_b     = in_b;
    end
  end

  assign st_busy = busy;
  assign st_done = (st_q == StDone);
  assign st_sig  = sig_q;
`else
  assign busy       = 1'b0;
  assign push_valid = in_valid;
  assign push_op    = in_op;
  assign push_a     = in_a;
  assign push_b     = in_b;
`endif

  assign in_ready  = ~full & ~busy;
  assign out_valid = out_valid_q & ~busy;
  assign out_data  = out_data_q;
  assign out_op    = out_op_q;
  assign level     = level_q;
  assign done_cnt  = done_cnt_q;

endmodule

// File: tb/tb_logic_op_sequencer.sv
// Scoreboard bench for logic_op_sequencer: accepted commands push their expected
// result; a negedge monitor pops and compares on each consumed output.
module tb_logic_op_sequencer;
  localparam int unsigned W     = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    in_op = '0;
  logic [W-1:0]  in_a = '0, in_b = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic [1:0]    out_op;
  logic [LW-1:0] level;
  logic [15:0]   done_cnt;
`ifdef LU_SELFTEST_EN
  logic          st_start = 1'b0;
  logic          st_busy, st_done;
  logic [15:0]   st_sig;
`endif

  logic_op_sequencer #(.W(W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_op    (out_op),
    .level     (level),
    .done_cnt  (done_cnt)
`ifdef LU_SELFTEST_EN
    ,
    .st_start  (st_start),
    .st_busy   (st_busy),
    .st_done   (st_done),
    .st_sig    (st_sig)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] d;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          m_cnt = 0;
  bit          m_ov = 0;
  logic [15:0] m_done = '0;
  bit          st_mode = 0;
  logic [15:0] bit0_hist = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_op(input logic [1:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return ~(a & b);
      default: return ~(a | b);
    endcase
  endfunction

  // Monitor and reference model, evaluated mid-cycle for the upcoming edge.
  always @(negedge clk) begin
    bit   do_pop, do_push;
    exp_t e;
    if (!rst_n) begin
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_done_cnt", 32'(done_cnt), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      m_cnt  = 0;
      m_ov   = 0;
      m_done = '0;
      sb.delete();
    end else if (!st_mode) begin
      chk("level", 32'(level), 32'(m_cnt));
      chk("out_valid", 32'(out_valid), 32'(m_ov));
      chk("in_ready", 32'(in_ready), 32'(m_cnt != DEPTH));
      chk("done_cnt", 32'(done_cnt), 32'(m_done));
      if (m_ov && out_ready && !flush) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("out_data", 32'(out_data), 32'(e.d));
          chk("out_op", 32'(out_op), 32'(e.op));
          bit0_hist = {bit0_hist[14:0], out_data[0]};
        end
      end
      if (m_ov && out_ready) m_done = m_done + 16'd1;
      if (flush) begin
        m_cnt = 0;
        m_ov  = 0;
        sb.delete();
      end else begin
        do_pop  = (m_cnt != 0) && (!m_ov || out_ready);
        do_push = in_valid && (m_cnt != DEPTH);
        if (do_push) begin
          e.op = in_op;
          e.d  = ref_op(in_op, in_a, in_b);
          sb.push_back(e);
        end
        m_cnt = m_cnt + int'(do_push) - int'(do_pop);
        if (do_pop) m_ov = 1;
        else if (m_ov && out_ready) m_ov = 0;
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bit ok = 0;
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    chk("send_accept", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] d0;
    // Reset
    #2 rst_n = 1'b0;
    cycles(3);
    rst_n = 1'b1;
    cycles(1);

    // Truth table, one result per cycle
    out_ready = 1'b1;
    bit0_hist = '0;
    for (int i = 0; i < 16; i++) begin
      logic [3:0] v;
      v = 4'(i);
      send(v[1:0], {W{v[3]}}, {W{v[2]}});
    end
    cycles(4);
    chk("t2_sequence", 32'(bit0_hist), 32'h366C);
    chk("t2_done_cnt", 32'(done_cnt), 32'd16);

    // Backpressure: 5 commands, one held in the output register
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(2'($urandom), W'($urandom), W'($urandom));
    @(negedge clk);
    chk("t3_level", 32'(level), 32'd4);
    chk("t3_in_ready", 32'(in_ready), 32'd0);
    repeat (3) @(negedge clk);
    chk("t3_hold", 32'(out_data), 32'(sb[0].d));
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t3_drain_valid", 32'(out_valid), 32'd1);
    end
    @(negedge clk);
    chk("t3_drain_end", 32'(out_valid), 32'd0);
    @(posedge clk); #1;

    // Full FIFO with a simultaneous pop: no push
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(2'($urandom), W'($urandom), W'($urandom));
    in_valid  = 1'b1;
    in_op     = 2'd1;
    in_a      = W'($urandom);
    in_b      = W'($urandom);
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    chk("t4_level", 32'(level), 32'd3);
    chk("t4_out_valid", 32'(out_valid), 32'd1);

    // Flush with level 3 and a held output
    d0 = m_done;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("t5_level", 32'(level), 32'd0);
    chk("t5_out_valid", 32'(out_valid), 32'd0);
    chk("t5_done_cnt", 32'(done_cnt), 32'(d0));
    @(posedge clk); #1;

    // Random traffic with random flushes and a mid-stream reset
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_op     = 2'($urandom);
      in_a      = W'($urandom);
      in_b      = W'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      rst_n     = !(i == 200 || i == 201);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    cycles(8);
    chk("sb_empty", 32'(sb.size()), 32'd0);

`ifdef LU_SELFTEST_EN
    begin
      int busy_n = 0;
      st_mode  = 1;
      st_start = 1'b1;
      @(posedge clk); #1;
      st_start = 1'b0;
      for (int k = 0; k < 200; k++) begin
        @(negedge clk);
        if (st_busy) busy_n++;
        if (st_done) break;
      end
      chk("t6_done", 32'(st_done), 32'd1);
      chk("t6_busy_long", 32'(busy_n >= 17), 32'd1);
      chk("t6_sig", 32'(st_sig), 32'h366C);
      chk("t6_done_cnt", 32'(done_cnt), 32'(m_done + 16'd16));
      m_done  = m_done + 16'd16;
      @(posedge clk); #1;
      st_mode = 0;
      cycles(2);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
